// File: rtl/binary_tree_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module  : binary_tree_mix_pkg
// Brief   : Shared state encoding, default phase lengths and timer sizing.
// Revision: 1.0 - initial release
// ============================================================================
package binary_tree_mix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_MIX   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int c_DEF_NUM_TREES    = 8;
    localparam int c_DEF_DEPTH        = 4;
    localparam int c_DEF_FILL_CYCLES  = 16;
    localparam int c_DEF_MIX_CYCLES   = 32;
    localparam int c_DEF_DRAIN_CYCLES = 16;
    localparam int c_MAX_PHASE_CYCLES = 255;

    // Bits needed to hold a load value of up to max_cycles-1 (8 for 255).
    function automatic int timer_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_tree_mix_seq_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : phase_timer
// Brief   : Loadable down-counter that stops at zero and flags it.
// Revision: 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/binary_tree_mix_seq.sv
`default_nettype none
// ============================================================================
// Module  : binary_tree_mix_seq
// Brief   : Sequences fill / per-level mix / drain valves of binary mixing trees.
// Revision: 1.0 - initial release
// ============================================================================
module binary_tree_mix_seq
    import binary_tree_mix_pkg::*;
#(
    parameter int NUM_TREES    = c_DEF_NUM_TREES,
    parameter int DEPTH        = c_DEF_DEPTH,
    parameter int FILL_CYCLES  = c_DEF_FILL_CYCLES,
    parameter int MIX_CYCLES   = c_DEF_MIX_CYCLES,
    parameter int DRAIN_CYCLES = c_DEF_DRAIN_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  logic [NUM_TREES-1:0]            tree_mask,
    input  logic                            abort,
    output logic [NUM_TREES*(2**DEPTH)-1:0] fill_en,
    output logic [NUM_TREES*DEPTH-1:0]      mix_en,
    output logic [NUM_TREES-1:0]            out_en,
    output logic                            busy,
    output logic                            done_valid,
    input  logic                            done_ready,
    output logic                            done_aborted
);

    localparam int c_LEAVES = 2 ** DEPTH;
    localparam int c_LVL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_TMR_W  = timer_width(c_MAX_PHASE_CYCLES);

    state_t                          state_q, state_d;
    logic [c_LVL_W-1:0]              level_q, level_d;
    logic [NUM_TREES-1:0]            mask_q, mask_d;
    logic                            done_aborted_q, done_aborted_d;
    logic                            start_ready_q, busy_q, done_valid_q;
    logic [NUM_TREES*c_LEAVES-1:0]   fill_en_q, fill_en_d;
    logic [NUM_TREES*DEPTH-1:0]      mix_en_q, mix_en_d;
    logic [NUM_TREES-1:0]            out_en_q, out_en_d;
    logic                            w_tmr_load;
    logic [c_TMR_W-1:0]              w_tmr_val;
    logic                            w_tmr_zero;
    logic                            w_start_hs;

    assign w_start_hs = start_valid & start_ready_q;

    phase_timer #(.WIDTH(c_TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .zero_o     (w_tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        mask_d         = mask_q;
        done_aborted_d = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_val      = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_start_hs) begin
                    mask_d = tree_mask;
                    if (tree_mask == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_FILL;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_TMR_W'(FILL_CYCLES - 1);
                    end
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_d        = ST_DONE;
                    done_aborted_d = 1'b1;
                end else if (w_tmr_zero) begin
                    state_d    = ST_MIX;
                    level_d    = c_LVL_W'(DEPTH - 1);
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_TMR_W'(MIX_CYCLES - 1);
                end
            end
            ST_MIX: begin
                if (abort) begin
                    state_d        = ST_DONE;
                    done_aborted_d = 1'b1;
                end else if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    if (level_q == '0) begin
                        state_d   = ST_DRAIN;
                        w_tmr_val = c_TMR_W'(DRAIN_CYCLES - 1);
                    end else begin
                        level_d   = level_q - 1'b1;
                        w_tmr_val = c_TMR_W'(MIX_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d        = ST_DONE;
                    done_aborted_d = 1'b1;
                end else if (w_tmr_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // abort is deliberately ignored here; only the consumer can leave DONE
                if (done_valid_q && done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    done_aborted_d = done_aborted_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Valve vectors are decoded from next-state so the registered outputs align with the state.
    for (genvar t = 0; t < NUM_TREES; t++) begin : g_tree
        for (genvar k = 0; k < c_LEAVES; k++) begin : g_leaf
            assign fill_en_d[t*c_LEAVES+k] = (state_d == ST_FILL) && mask_d[t];
        end
        for (genvar l = 0; l < DEPTH; l++) begin : g_level
            assign mix_en_d[t*DEPTH+l] = (state_d == ST_MIX) && mask_d[t] &&
                                         (level_d == c_LVL_W'(l));
        end
        assign out_en_d[t] = (state_d == ST_DRAIN) && mask_d[t];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            level_q        <= '0;
            mask_q         <= '0;
            done_aborted_q <= 1'b0;
            start_ready_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_valid_q   <= 1'b0;
            fill_en_q      <= '0;
            mix_en_q       <= '0;
            out_en_q       <= '0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            mask_q         <= mask_d;
            done_aborted_q <= done_aborted_d;
            start_ready_q  <= (state_d == ST_IDLE);
            busy_q         <= (state_d != ST_IDLE);
            done_valid_q   <= (state_d == ST_DONE);
            fill_en_q      <= fill_en_d;
            mix_en_q       <= mix_en_d;
            out_en_q       <= out_en_d;
        end
    end

    assign start_ready  = start_ready_q;
    assign busy         = busy_q;
    assign done_valid   = done_valid_q;
    assign done_aborted = done_aborted_q;
    assign fill_en      = fill_en_q;
    assign mix_en       = mix_en_q;
    assign out_en       = out_en_q;

endmodule
`default_nettype wire
